prio_encoder_rr: RTL and testbench

PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

---
 rtl/prio_encoder_rr_pkg.sv | 18 +
 rtl/prio_encoder_rr_if.sv | 38 +++
 rtl/prio_encoder_rr_search.sv | 54 +++++
 rtl/prio_encoder_rr.sv | 109 ++++++++++
 tb/tb_prio_encoder_rr.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/prio_encoder_rr_pkg.sv
// prio_enc_pkg: shared constants and helpers for the priority encoder.
// Holds the MODE selector values and the output-width helper used by the
// package users (search sub-module, top level and handshake interface).
package prio_enc_pkg;

    // Values accepted by the MODE parameter of prio_encoder_rr.
    localparam int PRIO_FIXED = 0;  // highest set index wins
    localparam int PRIO_RR    = 1;  // round-robin search from a rotating pointer

    // Width of an index into an n-bit vector, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/prio_encoder_rr_if.sv
// prio_encoder_rr_if: request/result handshake bundle of the priority encoder.
// slave is the encoder's view, master is the producer/consumer view.
interface prio_encoder_rr_if
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int IW = clog2_min1(WIDTH);

    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] d_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [IW-1:0]    y_o;
    logic             zero_o;

    modport slave (
        input  in_valid_i,
        input  d_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output y_o,
        output zero_o
    );

    modport master (
        output in_valid_i,
        output d_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  y_o,
        input  zero_o
    );

endinterface

// File: rtl/prio_encoder_rr_search.sv
// prio_search: purely combinational winner search.
// Fixed mode picks the highest set bit; round-robin mode scans upward from
// start_i, wrapping at WIDTH-1, and picks the first set bit. An all-zero
// vector reports index 0 with zero_o set.
module prio_search
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IW    = clog2_min1(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    input  logic [IW-1:0]    start_i,
    input  logic             mode_i,   // 1 = round-robin, 0 = fixed
    output logic [IW-1:0]    idx_o,
    output logic             zero_o
);
    // One extra bit so start + offset never overflows before the wrap test.
    localparam int PW = IW + 1;

    logic [WIDTH-1:0] rot_vec;          // vec_i rotated so bit 0 is at start_i
    logic [IW-1:0]    pos [WIDTH];      // original index of each rotated bit

    // Build the rotated view with an explicit modulo-WIDTH wrap, so
    // non-power-of-2 widths wrap at WIDTH-1 rather than at 2**IW-1.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
        logic [PW-1:0] sum;
        assign sum         = {1'b0, start_i} + PW'(gi);
        assign pos[gi]     = (sum >= PW'(WIDTH)) ? IW'(sum - PW'(WIDTH)) : sum[IW-1:0];
        assign rot_vec[gi] = vec_i[pos[gi]];
    end

    // Pick the winner: lowest rotated bit for round-robin, highest bit otherwise.
    always_comb begin
        logic found;
        idx_o  = '0;
        zero_o = ~|vec_i;
        found  = 1'b0;
        if (mode_i) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!found && rot_vec[i]) begin
                    idx_o = pos[i];
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec_i[i]) begin
                    idx_o = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered priority encoder with valid/ready handshake.
// One result register with 1-cycle latency; a drain and a new accept in the
// same cycle replace the result without a bubble. In round-robin mode a
// pointer advances past each winner so requesters are served in turn.
// Optional feature: define PRIO_ENC_MULTIHOT_CNT_EN to add multihot_cnt_o,
// a saturating count of accepted vectors with two or more bits set.
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = PRIO_FIXED,
    localparam int IW   = clog2_min1(WIDTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    prio_encoder_rr_if.slave  bus
`ifdef PRIO_ENC_MULTIHOT_CNT_EN
    ,
    output logic [7:0]        multihot_cnt_o
`endif
);
    logic          valid_q, valid_d;
    logic [IW-1:0] y_q, y_d;
    logic          zero_q, zero_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic          accept;
    logic [IW-1:0] win_idx;
    logic          win_zero;

    // Ready depends only on registered state and the consumer, never on in_valid_i.
    assign bus.in_ready_o  = !valid_q || bus.out_ready_i;
    assign accept          = bus.in_valid_i && bus.in_ready_o;

    assign bus.out_valid_o = valid_q;
    assign bus.y_o         = y_q;
    assign bus.zero_o      = zero_q;

    prio_search #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_search (
        .vec_i   (bus.d_i),
        .start_i (ptr_q),
        .mode_i  (MODE == PRIO_RR),
        .idx_o   (win_idx),
        .zero_o  (win_zero)
    );

    // Next result register and pointer: load on accept, clear on drain, else hold.
    always_comb begin
        valid_d = valid_q;
        y_d     = y_q;
        zero_d  = zero_q;
        ptr_d   = ptr_q;
        if (accept) begin
            valid_d = 1'b1;
            y_d     = win_idx;
            zero_d  = win_zero;
            if (MODE == PRIO_RR && !win_zero) begin
                ptr_d = (win_idx == IW'(WIDTH - 1)) ? '0 : win_idx + IW'(1);
            end
        end else if (bus.out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Result register and pointer; reset discards any pending result at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            zero_q  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef PRIO_ENC_MULTIHOT_CNT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       multihot;

    // Two or more bits set: clearing the lowest set bit leaves something behind.
    assign multihot       = |(bus.d_i & (bus.d_i - WIDTH'(1)));
    assign multihot_cnt_o = cnt_q;

    // Saturating increment on every multihot accept.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && multihot && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Multihot counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb_prio_encoder_rr: three encoders share one stimulus stream:
//   dut0 fixed priority, 8 bits; dut1 round-robin, 8 bits; dut2 round-robin,
//   5 bits (fed d[4:0]). A reference model pushes expected results into a
//   scoreboard queue on every accept; a separate monitor compares each
//   presented result against the queue head.
// Build with PRIO_ENC_MULTIHOT_CNT_EN defined to also exercise multihot_cnt_o.
module tb_prio_encoder_rr;
    import prio_enc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] d;
    logic       out_ready;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    prio_encoder_rr_if #(.WIDTH(8)) if0 ();
    prio_encoder_rr_if #(.WIDTH(8)) if1 ();
    prio_encoder_rr_if #(.WIDTH(5)) if2 ();

    assign if0.in_valid_i  = in_valid;
    assign if0.d_i         = d;
    assign if0.out_ready_i = out_ready;
    assign if1.in_valid_i  = in_valid;
    assign if1.d_i         = d;
    assign if1.out_ready_i = out_ready;
    assign if2.in_valid_i  = in_valid;
    assign if2.d_i         = d[4:0];
    assign if2.out_ready_i = out_ready;

`ifdef PRIO_ENC_MULTIHOT_CNT_EN
    logic [7:0] cnt0, cnt1, cnt2;
`endif

    prio_encoder_rr #(.WIDTH(8), .MODE(PRIO_FIXED)) dut0 (
        .clk_i (clk), .rst_ni (rst_n), .bus (if0)
`ifdef PRIO_ENC_MULTIHOT_CNT_EN
        , .multihot_cnt_o (cnt0)
`endif
    );
    prio_encoder_rr #(.WIDTH(8), .MODE(PRIO_RR)) dut1 (
        .clk_i (clk), .rst_ni (rst_n), .bus (if1)
`ifdef PRIO_ENC_MULTIHOT_CNT_EN
        , .multihot_cnt_o (cnt1)
`endif
    );
    prio_encoder_rr #(.WIDTH(5), .MODE(PRIO_RR)) dut2 (
        .clk_i (clk), .rst_ni (rst_n), .bus (if2)
`ifdef PRIO_ENC_MULTIHOT_CNT_EN
        , .multihot_cnt_o (cnt2)
`endif
    );

    typedef struct {
        int y0; bit z0;
        int y1; bit z1;
        int y2; bit z2;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input int expv);
        n_checks++;
        if (act !== 32'(expv)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: which request of a w-bit vector is served, given the rule.
    function automatic void ref_enc(input logic [7:0] v, input int w, input bit rr,
                                    input int p, output int y, output bit z);
        bit found;
        y = 0;
        z = 1'b1;
        for (int k = 0; k < w; k++) if (v[k]) z = 1'b0;
        found = 1'b0;
        if (!z) begin
            if (rr) begin
                for (int k = 0; k < w; k++) begin
                    int idx;
                    idx = (p + k) % w;
                    if (!found && v[idx]) begin
                        y = idx;
                        found = 1'b1;
                    end
                end
            end else begin
                for (int k = w - 1; k >= 0; k--) begin
                    if (!found && v[k]) begin
                        y = k;
                        found = 1'b1;
                    end
                end
            end
        end
    endfunction

    // Model state: is a result held, round-robin pointers, multihot counts.
    bit m_valid;
    bit m_ready;
    int p1, p2;
    int c0, c2;

    // Reference model: checks ready/valid each cycle, pushes expectations on accept.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            p1 = 0;
            p2 = 0;
            c0 = 0;
            c2 = 0;
            sb.delete();
        end else begin
            exp_t e;
            int   yy;
            bit   zz;
            m_ready = !m_valid || out_ready;
            chk("in_ready0", 32'(if0.in_ready_o), int'(m_ready));
            chk("in_ready1", 32'(if1.in_ready_o), int'(m_ready));
            chk("in_ready2", 32'(if2.in_ready_o), int'(m_ready));
            chk("out_valid0", 32'(if0.out_valid_o), int'(m_valid));
            chk("out_valid1", 32'(if1.out_valid_o), int'(m_valid));
            chk("out_valid2", 32'(if2.out_valid_o), int'(m_valid));
`ifdef PRIO_ENC_MULTIHOT_CNT_EN
            chk("multihot_cnt0", 32'(cnt0), c0);
            chk("multihot_cnt1", 32'(cnt1), c0);
            chk("multihot_cnt2", 32'(cnt2), c2);
`endif
            if (in_valid && m_ready) begin
                ref_enc(d, 8, 1'b0, 0, yy, zz);  e.y0 = yy; e.z0 = zz;
                ref_enc(d, 8, 1'b1, p1, yy, zz); e.y1 = yy; e.z1 = zz;
                ref_enc(d, 5, 1'b1, p2, yy, zz); e.y2 = yy; e.z2 = zz;
                if (!e.z1) p1 = (e.y1 + 1) % 8;
                if (!e.z2) p2 = (e.y2 + 1) % 5;
                if ($countones(d) >= 2 && c0 < 255) c0++;
                if ($countones(d[4:0]) >= 2 && c2 < 255) c2++;
                sb.push_back(e);
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Monitor: whenever a result is presented, compare it with the queue head;
    // pop only when the consumer takes it, so held results are rechecked.
    always @(negedge clk) begin
        if (rst_n && if0.out_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_result: got valid=1 expected no pending result");
            end else begin
                exp_t h;
                h = sb[0];
                chk("y0", 32'(if0.y_o), h.y0);
                chk("zero0", 32'(if0.zero_o), int'(h.z0));
                chk("y1", 32'(if1.y_o), h.y1);
                chk("zero1", 32'(if1.zero_o), int'(h.z1));
                chk("y2", 32'(if2.y_o), h.y2);
                chk("zero2", 32'(if2.zero_o), int'(h.z2));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] dd, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        d         = dd;
        out_ready = r;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid0"}, 32'(if0.out_valid_o), 0);
        chk({tag, "_y0"}, 32'(if0.y_o), 0);
        chk({tag, "_zero0"}, 32'(if0.zero_o), 0);
        chk({tag, "_valid1"}, 32'(if1.out_valid_o), 0);
        chk({tag, "_y1"}, 32'(if1.y_o), 0);
        chk({tag, "_zero1"}, 32'(if1.zero_o), 0);
        chk({tag, "_valid2"}, 32'(if2.out_valid_o), 0);
        chk({tag, "_y2"}, 32'(if2.y_o), 0);
        chk({tag, "_zero2"}, 32'(if2.zero_o), 0);
    endtask

    // Assert reset mid-cycle, check outputs clear without waiting for a clock edge.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_outputs_zero(tag);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        d         = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        // One-hot walk.
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(1 << i), 1'b1);
        drive(1'b0, 8'h00, 1'b1);

        // Mixed vector and all-zero vector.
        drive(1'b1, 8'b0010_1001, 1'b1);
        drive(1'b1, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);

        // Round-robin over all requests: 0..7,0,1 (and 0..4,0..4 on the 5-bit unit).
        do_reset("reset_rr8");
        for (int i = 0; i < 10; i++) drive(1'b1, 8'hFF, 1'b1);
        drive(1'b0, 8'h00, 1'b1);

        // Non-power-of-2 wrap: 0,4,0,4.
        do_reset("reset_rr5");
        for (int i = 0; i < 4; i++) drive(1'b1, 8'h11, 1'b1);
        drive(1'b0, 8'h00, 1'b1);

        // Backpressure: result held for 3 stalled cycles, then back-to-back accepts.
        drive(1'b1, 8'h40, 1'b1);
        drive(1'b1, 8'h81, 1'b0);
        drive(1'b1, 8'h81, 1'b0);
        drive(1'b1, 8'h81, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h0C << (i % 2)), 1'b1);
        drive(1'b0, 8'h00, 1'b1);

        // Reset while a result is pending and the round-robin pointer is 3.
        do_reset("reset_pre");
        for (int i = 0; i < 3; i++) drive(1'b1, 8'hFF, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        do_reset("reset_mid");
        drive(1'b1, 8'hFF, 1'b1);
        drive(1'b0, 8'h00, 1'b1);

        // Random traffic with random backpressure and occasional empty vectors.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] rd;
            rd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            drive(1'($urandom_range(0, 1)), rd, ($urandom_range(0, 3) != 0));
        end
        drive(1'b0, 8'h00, 1'b1);

`ifdef PRIO_ENC_MULTIHOT_CNT_EN
        // Saturation of the multihot counter.
        do_reset("reset_cnt");
        for (int i = 0; i < 300; i++) drive(1'b1, 8'h03, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        #2;
        chk("multihot_saturated", 32'(cnt0), 255);
`endif

        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
